// File: rtl/alu_control_mc.sv
// -----------------------------------------------------------------------------
// alu_control_mc
//   Registered ALU control unit for the execute stage. Decodes {ALUOp,
//   ALUFunction} into an ALU operation code, flags undecodable selectors and
//   sequences multi-cycle MULT/DIV operations. While a multi-cycle op runs,
//   busy stalls the issue stage. On completion, a HI/LO write-enable pulse is
//   produced.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-low reset
//   valid_i      in   decode request strobe (sampled only when not busy)
//   flush        in   abort in-flight multi-cycle op / drop current request
//   ALUOp        in   operation class from main control
//   ALUFunction  in   instruction funct field
//   ALUOperation out  registered ALU operation code
//   op_valid     out  one-cycle pulse: ALUOperation holds a completed result
//   busy         out  multi-cycle op in progress
//   hilo_we      out  one-cycle pulse with op_valid on MULT/DIV completion
//   illegal      out  one-cycle pulse with op_valid for undecodable selector
// -----------------------------------------------------------------------------
module alu_control_mc #(
  parameter int ALUOP_WIDTH  = 3,
  parameter int FUNCT_WIDTH  = 6,
  parameter int OPER_WIDTH   = 4,
  parameter int MULT_LATENCY = 4,
  parameter int DIV_LATENCY  = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   valid_i,
  input  logic                   flush,
  input  logic [ALUOP_WIDTH-1:0] ALUOp,
  input  logic [FUNCT_WIDTH-1:0] ALUFunction,
  output logic [OPER_WIDTH-1:0]  ALUOperation,
  output logic                   op_valid,
  output logic                   busy,
  output logic                   hilo_we,
  output logic                   illegal
);

  localparam int MAX_LAT = (MULT_LATENCY > DIV_LATENCY) ? MULT_LATENCY : DIV_LATENCY;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LATENCY - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LATENCY - 1);

  // Operation codes
  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_NOR  = 4'b0010;
  localparam logic [3:0] OP_ADD  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_LUI  = 4'b1000;
  localparam logic [3:0] OP_MULT = 4'b1001;
  localparam logic [3:0] OP_DIV  = 4'b1010;
  localparam logic [3:0] OP_ILL  = 4'b1111;

  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
    logic       ill;
    logic [3:0] code;
  } dec_t;

  // Selector decode. Non-R-type classes ignore the funct field entirely.
  function automatic dec_t decode(input logic [ALUOP_WIDTH-1:0] op,
                                  input logic [FUNCT_WIDTH-1:0] fn);
    dec_t d;
    d.ill  = 1'b0;
    d.code = OP_ILL;
    case (op)
      ALUOP_WIDTH'(3'b111): begin
        case (fn)
          FUNCT_WIDTH'(6'b100100): d.code = OP_AND;
          FUNCT_WIDTH'(6'b100101): d.code = OP_OR;
          FUNCT_WIDTH'(6'b100111): d.code = OP_NOR;
          FUNCT_WIDTH'(6'b100000): d.code = OP_ADD;
          FUNCT_WIDTH'(6'b000000): d.code = OP_SLL;
          FUNCT_WIDTH'(6'b000010): d.code = OP_SRL;
          FUNCT_WIDTH'(6'b100010): d.code = OP_SUB;
          FUNCT_WIDTH'(6'b101010): d.code = OP_SLT;
          FUNCT_WIDTH'(6'b011000): d.code = OP_MULT;
          FUNCT_WIDTH'(6'b011010): d.code = OP_DIV;
          default:                 d.ill  = 1'b1;
        endcase
      end
      ALUOP_WIDTH'(3'b100): d.code = OP_ADD;  // ADDI
      ALUOP_WIDTH'(3'b101): d.code = OP_AND;  // ANDI
      ALUOP_WIDTH'(3'b110): d.code = OP_OR;   // ORI
      ALUOP_WIDTH'(3'b011): d.code = OP_LUI;  // LUI
      ALUOP_WIDTH'(3'b001): d.code = OP_SUB;  // BEQ/BNE
      ALUOP_WIDTH'(3'b000): d.code = OP_ADD;  // LW/SW
      default:              d.ill  = 1'b1;
    endcase
    return d;
  endfunction

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [OPER_WIDTH-1:0] oper_q, oper_d;
  logic                  op_valid_q, op_valid_d;
  logic                  hilo_we_q, hilo_we_d;
  logic                  illegal_q, illegal_d;
  dec_t                  dec;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    oper_d     = oper_q;
    op_valid_d = 1'b0;
    hilo_we_d  = 1'b0;
    illegal_d  = 1'b0;
    dec        = decode(ALUOp, ALUFunction);

    case (state_q)
      IDLE: begin
        // flush drops the request outright; nothing is registered.
        if (valid_i && !flush) begin
          oper_d = OPER_WIDTH'(dec.code);
          if (dec.code == OP_MULT || dec.code == OP_DIV) begin
            state_d = RUN;
            cnt_d   = (dec.code == OP_MULT) ? MULT_LOAD : DIV_LOAD;
          end else begin
            op_valid_d = 1'b1;
            illegal_d  = dec.ill;
          end
        end
      end
      RUN: begin
        if (flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d    = IDLE;
          op_valid_d = 1'b1;
          hilo_we_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      oper_q     <= OPER_WIDTH'(OP_ILL);
      op_valid_q <= 1'b0;
      hilo_we_q  <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      oper_q     <= oper_d;
      op_valid_q <= op_valid_d;
      hilo_we_q  <= hilo_we_d;
      illegal_q  <= illegal_d;
    end
  end

  assign ALUOperation = oper_q;
  assign op_valid     = op_valid_q;
  assign busy         = (state_q == RUN);
  assign hilo_we      = hilo_we_q;
  assign illegal      = illegal_q;

endmodule

// File: tb/tb_alu_control_mc.sv
// -----------------------------------------------------------------------------
// tb_alu_control_mc
//   Scoreboard bench for alu_control_mc. Stimulus pushes expected completions
//   into a queue; a monitor pops and compares whenever op_valid is seen.
// -----------------------------------------------------------------------------
module tb_alu_control_mc;

  logic       clk = 1'b0;
  logic       reset;
  logic       valid_i;
  logic       flush;
  logic [2:0] ALUOp;
  logic [5:0] ALUFunction;
  logic [3:0] ALUOperation;
  logic       op_valid;
  logic       busy;
  logic       hilo_we;
  logic       illegal;

  alu_control_mc dut (
    .clk          (clk),
    .reset        (reset),
    .valid_i      (valid_i),
    .flush        (flush),
    .ALUOp        (ALUOp),
    .ALUFunction  (ALUFunction),
    .ALUOperation (ALUOperation),
    .op_valid     (op_valid),
    .busy         (busy),
    .hilo_we      (hilo_we),
    .illegal      (illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] oper;
    logic       hilo;
    logic       ill;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge and record its expected completion.
  task automatic issue(input logic [2:0] op, input logic [5:0] fn,
                       input logic [3:0] eo, input logic eh, input logic ei);
    exp_t e;
    ALUOp       = op;
    ALUFunction = fn;
    valid_i     = 1'b1;
    e.oper = eo; e.hilo = eh; e.ill = ei;
    sb.push_back(e);
    tick();
  endtask

  // Present a multi-cycle request that is not expected to complete.
  task automatic issue_nocomplete(input logic [2:0] op, input logic [5:0] fn);
    ALUOp       = op;
    ALUFunction = fn;
    valid_i     = 1'b1;
    tick();
    valid_i = 1'b0;
  endtask

  // Monitor: every op_valid must match the oldest expected completion.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (op_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_op_valid", {31'b0, op_valid}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("completion{oper,hilo,ill}", {26'b0, ALUOperation, hilo_we, illegal},
              {26'b0, e.oper, e.hilo, e.ill});
        end
      end else if (hilo_we || illegal) begin
        chk("stray_flag{hilo,ill}", {30'b0, hilo_we, illegal}, 32'd0);
      end
    end
  end

  initial begin
    reset = 1'b0; valid_i = 1'b1; flush = 1'b0;
    ALUOp = 3'b111; ALUFunction = 6'b100000;

    // Reset held with a live ADD request
    tick(); tick();
    chk("reset_oper",     ALUOperation, 4'hF);
    chk("reset_op_valid", op_valid, 0);
    chk("reset_busy",     busy, 0);
    chk("reset_hilo",     hilo_we, 0);
    chk("reset_illegal",  illegal, 0);
    reset = 1'b1;
    issue(3'b111, 6'b100000, 4'h3, 0, 0);
    chk("add_op_valid", op_valid, 1);
    chk("add_oper",     ALUOperation, 4'h3);
    valid_i = 1'b0;
    tick();
    chk("add_pulse_one_cycle", op_valid, 0);
    chk("oper_holds", ALUOperation, 4'h3);

    // I-type ignores funct; back-to-back acceptance
    issue(3'b100, 6'b101010, 4'h3, 0, 0);
    issue(3'b101, 6'b111111, 4'h0, 0, 0);
    chk("b2b_valid_1", op_valid, 1);
    issue(3'b110, 6'b000000, 4'h1, 0, 0);
    chk("b2b_valid_2", op_valid, 1);
    issue(3'b011, 6'b011000, 4'h8, 0, 0);
    chk("b2b_valid_3", op_valid, 1);

    // Remaining decode table
    issue(3'b111, 6'b100100, 4'h0, 0, 0);
    issue(3'b111, 6'b100101, 4'h1, 0, 0);
    issue(3'b111, 6'b100111, 4'h2, 0, 0);
    issue(3'b111, 6'b000000, 4'h4, 0, 0);
    issue(3'b111, 6'b000010, 4'h5, 0, 0);
    issue(3'b111, 6'b100010, 4'h6, 0, 0);
    issue(3'b111, 6'b101010, 4'h7, 0, 0);
    issue(3'b001, 6'b100000, 4'h6, 0, 0);
    issue(3'b000, 6'b100100, 4'h3, 0, 0);
    valid_i = 1'b0;
    tick();

    // MULT: busy cycles 1-4, completion in cycle 5; ADD in cycle 2 ignored
    issue(3'b111, 6'b011000, 4'h9, 1, 0);
    valid_i = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      chk("mult_busy",     busy, 1);
      chk("mult_no_valid", op_valid, 0);
      chk("mult_oper",     ALUOperation, 4'h9);
      if (c == 2) begin
        ALUOp = 3'b111; ALUFunction = 6'b100000; valid_i = 1'b1;
      end else begin
        valid_i = 1'b0;
      end
      tick();
    end
    chk("mult_done_busy", busy, 0);
    chk("mult_done_valid", op_valid, 1);
    chk("mult_done_hilo",  hilo_we, 1);
    tick();
    chk("mult_after_valid", op_valid, 0);
    chk("mult_after_oper", ALUOperation, 4'h9);

    // DIV flushed in cycle 10
    issue_nocomplete(3'b111, 6'b011010);
    for (int c = 1; c < 10; c++) tick();
    chk("div_busy_c10", busy, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy",  busy, 0);
    chk("flush_valid", op_valid, 0);
    chk("flush_oper",  ALUOperation, 4'hA);
    for (int c = 0; c < 30; c++) tick();
    chk("flush_still_idle", busy, 0);
    issue(3'b111, 6'b100000, 4'h3, 0, 0);
    valid_i = 1'b0;
    chk("post_flush_add", ALUOperation, 4'h3);

    // Flush in IDLE drops the request
    ALUOp = 3'b101; valid_i = 1'b1; flush = 1'b1;
    tick();
    valid_i = 1'b0; flush = 1'b0;
    chk("idle_flush_oper",  ALUOperation, 4'h3);
    chk("idle_flush_valid", op_valid, 0);

    // Illegal selectors
    issue(3'b111, 6'b111111, 4'hF, 0, 1);
    chk("ill_r_illegal", illegal, 1);
    chk("ill_r_busy",    busy, 0);
    issue(3'b010, 6'b100000, 4'hF, 0, 1);
    chk("ill_op_illegal", illegal, 1);
    valid_i = 1'b0;
    tick();
    chk("ill_pulse_one_cycle", illegal, 0);

    // Reset mid-DIV when counter is 20 (cycle 12)
    issue_nocomplete(3'b111, 6'b011010);
    for (int c = 1; c < 12; c++) tick();
    chk("div_busy_c12", busy, 1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("midrun_busy",  busy, 0);
    chk("midrun_valid", op_valid, 0);
    chk("midrun_hilo",  hilo_we, 0);
    chk("midrun_oper",  ALUOperation, 4'hF);
    for (int c = 0; c < 40; c++) tick();
    chk("midrun_idle", busy, 0);

    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
